// File: rtl/cnt_seq_ctrl.sv
// Sequencer for a cascaded presettable up/down counter: load, verify, pulse until target.
// Optional CNT_SEQ_TIMEOUT_EN adds a pulse-count timeout that ends a run in FAIL.
module cnt_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] target,
    input  logic             dir,
    input  logic [WIDTH-1:0] cnt_q,
    input  logic             co,
    input  logic             bo,
    output logic             preset_n,
    output logic [WIDTH-1:0] load_data,
    output logic             up_p,
    output logic             dn_p,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             wrap
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LSETTLE,
        CHECK,
        COUNT,
        CSETTLE,
        FIN,
        FAIL
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] target_q;
    logic             dir_q;
`ifdef CNT_SEQ_TIMEOUT_EN
    localparam logic [WIDTH:0] PULSE_LIMIT = {1'b1, {WIDTH{1'b0}}};
    logic [WIDTH:0]   pulse_cnt;
`endif

    // Outputs are registered alongside the state, so each strobe is visible
    // for the cycle following the decision that produced it; load_data doubles
    // as the latched preset value that CHECK compares against.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            target_q   <= '0;
            dir_q      <= 1'b0;
            preset_n   <= 1'b1;
            load_data  <= '0;
            up_p       <= 1'b0;
            dn_p       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            wrap       <= 1'b0;
`ifdef CNT_SEQ_TIMEOUT_EN
            pulse_cnt  <= '0;
`endif
        end else begin
            preset_n <= 1'b1;
            up_p     <= 1'b0;
            dn_p     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            if (state != IDLE && abort) begin
                state      <= IDLE;
                busy       <= 1'b0;
                settle_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            load_data <= load_val;
                            target_q  <= target;
                            dir_q     <= dir;
                            wrap      <= 1'b0;
                            preset_n  <= 1'b0;
                            busy      <= 1'b1;
                            state     <= LOAD;
`ifdef CNT_SEQ_TIMEOUT_EN
                            pulse_cnt <= '0;
`endif
                        end
                    end
                    LOAD: begin
                        settle_cnt <= SETTLE_LAST;
                        state      <= LSETTLE;
                    end
                    LSETTLE: begin
                        if (settle_cnt == 4'd0) begin
                            state <= CHECK;
                        end else begin
                            settle_cnt <= settle_cnt - 4'd1;
                        end
                    end
                    CHECK: begin
                        if (cnt_q != load_data) begin
                            err   <= 1'b1;
                            state <= FAIL;
                        end else begin
                            state <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (cnt_q == target_q) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
`ifdef CNT_SEQ_TIMEOUT_EN
                        else if (pulse_cnt == PULSE_LIMIT) begin
                            err   <= 1'b1;
                            state <= FAIL;
                        end
`endif
                        else begin
                            up_p       <= dir_q;
                            dn_p       <= !dir_q;
                            settle_cnt <= SETTLE_LAST;
                            state      <= CSETTLE;
`ifdef CNT_SEQ_TIMEOUT_EN
                            pulse_cnt  <= pulse_cnt + (WIDTH+1)'(1);
`endif
                        end
                    end
                    CSETTLE: begin
                        // Carry/borrow accompanies the pulse that crosses the boundary.
                        if ((dir_q && co) || (!dir_q && bo)) begin
                            wrap <= 1'b1;
                        end
                        if (settle_cnt == 4'd0) begin
                            state <= COUNT;
                        end else begin
                            settle_cnt <= settle_cnt - 4'd1;
                        end
                    end
                    FIN, FAIL: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Scoreboard bench for cnt_seq_ctrl driving a behavioural counter model.
// Follows CNT_SEQ_TIMEOUT_EN to pick the matching timeout expectation.
module tb_cnt_seq_ctrl;

    localparam int WIDTH  = 8;
    localparam int SETTLE = 2;
    localparam int NO_GAP = 9999;

    typedef struct {
        string      name;
        logic       exp_done;
        logic       exp_err;
        int         ups;
        int         dns;
        int         presets;
        logic       exp_wrap;
        int         min_gap;
        logic [7:0] final_cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] target = 8'h00;
    logic [7:0] cnt_q;
    logic       co;
    logic       bo;
    logic       preset_n;
    logic [7:0] load_data;
    logic       up_p;
    logic       dn_p;
    logic       busy;
    logic       done;
    logic       err;
    logic       wrap;

    int   compared = 0;
    int   mismatched = 0;
    exp_t exp_q[$];

    int         model_mode = 0;
    logic [7:0] cnt = 8'h00;
    int         cyc = 0;
    int         up_seen = 0;
    int         dn_seen = 0;
    int         preset_seen = 0;
    int         done_seen = 0;
    int         err_seen = 0;
    int         overlap_seen = 0;
    int         min_gap = NO_GAP;
    int         last_pulse = -1;
    logic       run_ended = 1'b0;

    cnt_seq_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .load_val  (load_val),
        .target    (target),
        .dir       (dir),
        .cnt_q     (cnt_q),
        .co        (co),
        .bo        (bo),
        .preset_n  (preset_n),
        .load_data (load_data),
        .up_p      (up_p),
        .dn_p      (dn_p),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    // Counter model: mode 0 normal, mode 1 ignores loads (stuck at 0), mode 2 loads but never counts.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (model_mode == 1) cnt <= 8'h00;
        else if (!preset_n) cnt <= load_data;
        else if (model_mode == 0 && up_p) cnt <= cnt + 8'd1;
        else if (model_mode == 0 && dn_p) cnt <= cnt - 8'd1;
    end

    assign cnt_q = cnt;
    assign co    = up_p && (cnt == 8'hFF);
    assign bo    = dn_p && (cnt == 8'h00);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t mkExp(input string n, input logic d, input logic er, input int u,
                                   input int dn, input logic w, input logic [7:0] fc);
        exp_t r;
        r.name      = n;
        r.exp_done  = d;
        r.exp_err   = er;
        r.ups       = u;
        r.dns       = dn;
        r.presets   = 1;
        r.exp_wrap  = w;
        r.final_cnt = fc;
        r.min_gap   = (u + dn >= 2) ? SETTLE + 1 : NO_GAP;
        return r;
    endfunction

    // Monitor: tallies strobes each cycle and scores a run when it ends in DONE or ERR.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!preset_n) preset_seen++;
        if (up_p) up_seen++;
        if (dn_p) dn_seen++;
        if ((up_p && dn_p) || ((up_p || dn_p) && !preset_n)) overlap_seen++;
        if (up_p || dn_p) begin
            if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
        end
        if (done) done_seen++;
        if (err) err_seen++;
        if (done || err) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_end", {30'd0, done, err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput($sformatf("%s_done", e.name), done, e.exp_done);
                checkOutput($sformatf("%s_err", e.name), err, e.exp_err);
                checkOutput($sformatf("%s_ups", e.name), up_seen, e.ups);
                checkOutput($sformatf("%s_dns", e.name), dn_seen, e.dns);
                checkOutput($sformatf("%s_presets", e.name), preset_seen, e.presets);
                checkOutput($sformatf("%s_wrap", e.name), wrap, e.exp_wrap);
                checkOutput($sformatf("%s_gap", e.name), min_gap, e.min_gap);
                checkOutput($sformatf("%s_overlap", e.name), overlap_seen, 0);
                checkOutput($sformatf("%s_cnt", e.name), cnt, e.final_cnt);
                checkOutput($sformatf("%s_busy", e.name), busy, 1);
            end
            run_ended = 1'b1;
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_preset_n"}, preset_n, 1);
        checkOutput({tag, "_load_data"}, load_data, 0);
        checkOutput({tag, "_up_p"}, up_p, 0);
        checkOutput({tag, "_dn_p"}, dn_p, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_wrap"}, wrap, 0);
    endtask

    // Starts a run, then scrambles the run inputs and re-requests START while busy.
    task automatic applyStimulus(input logic [7:0] lv, input logic [7:0] tg, input logic d,
                                 input int mode, input logic expect_end, input exp_t e);
        @(posedge clk); #1;
        model_mode   = mode;
        load_val     = lv;
        target       = tg;
        dir          = d;
        start        = 1'b1;
        up_seen      = 0;
        dn_seen      = 0;
        preset_seen  = 0;
        done_seen    = 0;
        err_seen     = 0;
        overlap_seen = 0;
        min_gap      = NO_GAP;
        last_pulse   = -1;
        run_ended    = 1'b0;
        if (expect_end) exp_q.push_back(e);
        @(posedge clk); #1;
        start    = 1'b0;
        load_val = ~lv;
        target   = ~tg;
        dir      = ~d;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitEnd(input string tag, input int budget);
        int n = 0;
        while (!run_ended && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, "_ended"}, run_ended, 1);
        if (!run_ended && exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (2) @(posedge clk);
        #1;
        checkOutput({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        exp_t e;
        int   n;
        e = mkExp("none", 0, 0, 0, 0, 0, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b0;

        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_over_start_busy", busy, 0);
        checkOutput("abort_over_start_preset_n", preset_n, 1);

        applyStimulus(8'h17, 8'h1A, 1'b1, 0, 1'b1, mkExp("up_3", 1, 0, 3, 0, 0, 8'h1A));
        waitEnd("up_3", 200);
        applyStimulus(8'hFE, 8'h01, 1'b1, 0, 1'b1, mkExp("wrap_up", 1, 0, 3, 0, 1, 8'h01));
        waitEnd("wrap_up", 200);
        applyStimulus(8'h05, 8'h05, 1'b1, 0, 1'b1, mkExp("equal", 1, 0, 0, 0, 0, 8'h05));
        waitEnd("equal", 200);
        applyStimulus(8'h10, 8'h0C, 1'b0, 0, 1'b1, mkExp("down_4", 1, 0, 0, 4, 0, 8'h0C));
        waitEnd("down_4", 200);
        applyStimulus(8'h01, 8'hFE, 1'b0, 0, 1'b1, mkExp("wrap_down", 1, 0, 0, 3, 1, 8'hFE));
        waitEnd("wrap_down", 200);
        applyStimulus(8'h30, 8'h35, 1'b1, 1, 1'b1, mkExp("bad_load", 0, 1, 0, 0, 0, 8'h00));
        waitEnd("bad_load", 200);

        applyStimulus(8'h10, 8'h08, 1'b0, 0, 1'b0, e);
        n = 0;
        while (dn_seen < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("abort_two_pulses", dn_seen, 2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abort_no_more_pulses", dn_seen, 2);
        checkOutput("abort_no_done", done_seen, 0);
        checkOutput("abort_no_err", err_seen, 0);
        checkOutput("abort_cnt", cnt, 8'h0E);

        applyStimulus(8'h20, 8'h30, 1'b1, 0, 1'b0, e);
        n = 0;
        while (up_seen < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("midrun_three_pulses", up_seen, 3);
        rst   = 1'b1;
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        checkResetState("midrun_reset");
        rst   = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("midrun_no_more_pulses", up_seen, 3);
        checkOutput("midrun_no_done", done_seen, 0);
        checkOutput("midrun_idle", busy, 0);

`ifdef CNT_SEQ_TIMEOUT_EN
        applyStimulus(8'h40, 8'h41, 1'b1, 2, 1'b1, mkExp("timeout", 0, 1, 256, 0, 0, 8'h40));
        waitEnd("timeout", 1500);
`else
        applyStimulus(8'h40, 8'h41, 1'b1, 2, 1'b0, e);
        n = 0;
        while (up_seen < 300 && n < 1500) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("no_timeout_pulses", up_seen >= 300, 1);
        checkOutput("no_timeout_err", err_seen, 0);
        checkOutput("no_timeout_busy", busy, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("no_timeout_abort_idle", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no completion, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
